// File: rtl/div16by8_seq.sv
// Sequential radix-2 restoring divider: NW-bit dividend / DW-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module div16by8_seq #(
  parameter int NW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] q,
  output logic [DW-1:0] r,
  output logic          div0
);

  localparam int CW = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [NW-1:0] dvd;
  logic [NW-1:0] quo;
  logic [DW-1:0] dsr;
  logic [DW-1:0] prem;
  logic [CW-1:0] cnt;
  logic          zero_div;
  logic          accept;
  logic          last_step;
  logic [DW:0]   step;

  // The trial remainder p is DW+1 bits, but after a successful subtract it is
  // below the divisor, so the low DW bits of the difference are exact.
  function automatic logic [DW:0] restore_step(input logic [DW-1:0] rem,
                                               input logic          msb,
                                               input logic [DW-1:0] d);
    logic [DW:0] p;
    logic        ge;
    p  = {rem, msb};
    ge = (p >= {1'b0, d});
    restore_step = {(ge ? (p[DW-1:0] - d) : p[DW-1:0]), ge};
  endfunction

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign step      = restore_step(prem, dvd[NW-1], dsr);
  assign last_step = (cnt == CW'(NW - 1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (zero_div || last_step) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero divisor spends a single RUN cycle and skips the iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd      <= '0;
      dsr      <= '0;
      prem     <= '0;
      quo      <= '0;
      cnt      <= '0;
      zero_div <= 1'b0;
      q        <= '0;
      r        <= '0;
      div0     <= 1'b0;
    end else if (accept) begin
      dvd      <= a;
      dsr      <= b;
      prem     <= '0;
      quo      <= '0;
      cnt      <= '0;
      zero_div <= (b == '0);
    end else if (state == RUN) begin
      if (zero_div) begin
        q    <= '1;
        r    <= dvd[DW-1:0];
        div0 <= 1'b1;
      end else begin
        dvd  <= dvd << 1;
        prem <= step[DW:1];
        quo  <= {quo[NW-2:0], step[0]};
        cnt  <= cnt + 1'b1;
        if (last_step) begin
          q    <= {quo[NW-2:0], step[0]};
          r    <= step[DW:1];
          div0 <= 1'b0;
        end
      end
    end
  end

endmodule
